ddr3_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the single `ddr3_rd_control` DDR3 read engine between two command state machines. Requester 0 is the fill readout (`CC_RD_FILL`); requester 1 is a second reader such as a raw memory dump. It sits between the command state machines and `ddr3_rd_control`. It latches the granted requester's start address and burst count, runs the four-phase enable/done handshake with the reader, and reports completion or a timeout back to the owner. It also drives a one-hot grant that the AXIS mux uses for steering.

---
 rtl/ddr3_rd_defs.sv | 22 ++
 rtl/sync2.sv | 21 ++
 rtl/ddr3_rd_arbiter.sv | 159 +++++++++++++++
 tb/tb_ddr3_rd_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_rd_defs.sv
// Shared widths, state indices and requester indices for the DDR3 read path.
package ddr3_rd_defs;

  localparam int unsigned DDR3_ADDR_W  = 23;
  localparam int unsigned DDR3_BURST_W = 24;

  localparam int unsigned IDLE    = 0;
  localparam int unsigned RUN     = 1;
  localparam int unsigned RELEASE = 2;
  localparam int unsigned DRAIN   = 3;

  localparam int unsigned REQ_FILL = 0;
  localparam int unsigned REQ_MEM  = 1;

  typedef enum logic [3:0] {
    StIdle    = 4'b0001 << IDLE,
    StRun     = 4'b0001 << RUN,
    StRelease = 4'b0001 << RELEASE,
    StDrain   = 4'b0001 << DRAIN
  } arb_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter sharing one DDR3 read engine between two requesters,
// with a four-phase enable/done handshake and a RUN-state watchdog.
module ddr3_rd_arbiter
  import ddr3_rd_defs::*;
#(
  parameter int unsigned TIMEOUT_W = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_en,
  input  logic [DDR3_ADDR_W-1:0]  req_start_addr0,
  input  logic [DDR3_ADDR_W-1:0]  req_start_addr1,
  input  logic [DDR3_BURST_W-1:0] req_burst_cnt0,
  input  logic [DDR3_BURST_W-1:0] req_burst_cnt1,
  output logic [1:0]              req_done,
  output logic [1:0]              req_err,
  output logic [1:0]              grant,
  output logic [DDR3_ADDR_W-1:0]  ddr3_rd_start_addr,
  output logic [DDR3_BURST_W-1:0] ddr3_rd_burst_cnt,
  output logic                    enable_reading,
  input  logic                    reading_done,
  output logic                    busy,
  output logic                    timeout_seen,
  input  logic                    clr_timeout
);

  arb_state_e              state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    last_gnt_q, last_gnt_d;
  logic [DDR3_ADDR_W-1:0]  addr_q, addr_d;
  logic [DDR3_BURST_W-1:0] cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              err_q, err_d;
  logic [TIMEOUT_W-1:0]    wdog_q, wdog_d;
  logic                    tmo_q, tmo_d;
  logic                    done_s;
  logic                    sel;
  logic                    gidx;
  logic                    set_tmo;
  logic [DDR3_BURST_W-1:0] cnt_sel;

  sync2 u_done_sync (
    .clk   (clk),
    .reset (reset),
    .d     (reading_done),
    .q     (done_s)
  );

  assign gidx = grant_q[REQ_MEM];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    done_d     = done_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    set_tmo    = 1'b0;
    sel        = 1'b0;
    cnt_sel    = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_en) begin
          // On a tie the requester not served last wins.
          sel        = (req_en == 2'b11) ? ~last_gnt_q : req_en[REQ_MEM];
          cnt_sel    = sel ? req_burst_cnt1 : req_burst_cnt0;
          grant_d    = sel ? 2'b10 : 2'b01;
          last_gnt_d = sel;
          addr_d     = sel ? req_start_addr1 : req_start_addr0;
          cnt_d      = cnt_sel;
          if (cnt_sel != '0) begin
            state_d = StRun;
            en_d    = 1'b1;
            wdog_d  = '0;
          end else begin
            state_d      = StRelease;
            done_d[sel]  = 1'b1;
          end
        end
      end
      StRun: begin
        wdog_d = wdog_q + 1'b1;
        if (done_s) begin
          state_d      = StRelease;
          done_d[gidx] = 1'b1;
        end else if (&wdog_d) begin
          state_d      = StRelease;
          done_d[gidx] = 1'b1;
          err_d[gidx]  = 1'b1;
          set_tmo      = 1'b1;
        end
      end
      StRelease: begin
        if (!req_en[gidx]) begin
          state_d = StDrain;
          done_d  = '0;
          err_d   = '0;
          en_d    = 1'b0;
        end
      end
      StDrain: begin
        if (!done_s) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        en_d    = 1'b0;
        done_d  = '0;
        err_d   = '0;
      end
    endcase

    tmo_d = clr_timeout ? 1'b0 : (tmo_q | set_tmo);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      wdog_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
      tmo_q      <= tmo_d;
    end
  end

  assign req_done           = done_q;
  assign req_err            = err_q;
  assign grant              = grant_q;
  assign ddr3_rd_start_addr = addr_q;
  assign ddr3_rd_burst_cnt  = cnt_q;
  assign enable_reading     = en_q;
  assign timeout_seen       = tmo_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Directed bench for ddr3_rd_arbiter: single read, tie, zero count, timeout, mid-read reset.
module tb_ddr3_rd_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_en;
  logic [22:0] addr0, addr1;
  logic [23:0] cnt0, cnt1;
  logic        reading_done;
  logic        clr_timeout;

  logic [1:0]  done, err, grant;
  logic [22:0] rd_addr;
  logic [23:0] rd_cnt;
  logic        en, busy, tmo;

  logic [1:0]  done_t, err_t, grant_t;
  logic [22:0] rd_addr_t;
  logic [23:0] rd_cnt_t;
  logic        en_t, busy_t, tmo_t;

  int checks = 0;
  int errors = 0;

  ddr3_rd_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .req_en             (req_en),
    .req_start_addr0    (addr0),
    .req_start_addr1    (addr1),
    .req_burst_cnt0     (cnt0),
    .req_burst_cnt1     (cnt1),
    .req_done           (done),
    .req_err            (err),
    .grant              (grant),
    .ddr3_rd_start_addr (rd_addr),
    .ddr3_rd_burst_cnt  (rd_cnt),
    .enable_reading     (en),
    .reading_done       (reading_done),
    .busy               (busy),
    .timeout_seen       (tmo),
    .clr_timeout        (clr_timeout)
  );

  // Short watchdog instance for the timeout scenario.
  ddr3_rd_arbiter #(.TIMEOUT_W(4)) dut_t (
    .clk                (clk),
    .reset              (reset),
    .req_en             (req_en),
    .req_start_addr0    (addr0),
    .req_start_addr1    (addr1),
    .req_burst_cnt0     (cnt0),
    .req_burst_cnt1     (cnt1),
    .req_done           (done_t),
    .req_err            (err_t),
    .grant              (grant_t),
    .ddr3_rd_start_addr (rd_addr_t),
    .ddr3_rd_burst_cnt  (rd_cnt_t),
    .enable_reading     (en_t),
    .reading_done       (reading_done),
    .busy               (busy_t),
    .timeout_seen       (tmo_t),
    .clr_timeout        (clr_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] want);
    for (int i = 0; i < 12; i++) begin
      if (grant == want) break;
      step(1);
    end
    check(tag, 64'(grant), 64'(want));
  endtask

  task automatic wait_done(input string tag, input logic [1:0] want);
    for (int i = 0; i < 12; i++) begin
      if (done == want) break;
      step(1);
    end
    check(tag, 64'(done), 64'(want));
  endtask

  // Serve the current grant as a reader would, optionally re-raising the request.
  task automatic serve(input logic [1:0] exp, input logic reraise);
    wait_grant("tie_grant", exp);
    step(2);
    reading_done = 1'b1;
    wait_done("tie_done", exp);
    req_en       = req_en & ~exp;
    reading_done = 1'b0;
    wait_grant("tie_release", 2'b00);
    if (reraise) req_en = req_en | exp;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset        = 1'b0;
    req_en       = 2'b00;
    addr0        = '0;
    addr1        = '0;
    cnt0         = '0;
    cnt1         = '0;
    reading_done = 1'b0;
    clr_timeout  = 1'b0;
    step(2);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_en", 64'(en), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_addr", 64'(rd_addr), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_tmo", 64'(tmo), 64'h0);
    reset = 1'b1;
    step(1);

    // Single read from requester 0.
    addr0  = 23'h001000;
    cnt0   = 24'h000040;
    req_en = 2'b01;
    step(1);
    check("single_grant", 64'(grant), 64'h1);
    check("single_addr", 64'(rd_addr), 64'h001000);
    check("single_cnt", 64'(rd_cnt), 64'h000040);
    check("single_en", 64'(en), 64'h1);
    check("single_busy", 64'(busy), 64'h1);
    step(20);
    reading_done = 1'b1;
    step(2);
    check("single_done_early", 64'(done), 64'h0);
    step(1);
    check("single_done", 64'(done), 64'h1);
    check("single_err", 64'(err), 64'h0);
    check("single_en_hold", 64'(en), 64'h1);
    req_en = 2'b00;
    step(1);
    check("single_en_fall", 64'(en), 64'h0);
    check("single_done_fall", 64'(done), 64'h0);
    check("single_grant_hold", 64'(grant), 64'h1);
    reading_done = 1'b0;
    step(2);
    check("single_drain", 64'(grant), 64'h1);
    step(1);
    check("single_grant_clr", 64'(grant), 64'h0);
    check("single_busy_clr", 64'(busy), 64'h0);

    // Tie from reset: 0, then 1, then 0 again.
    do_reset();
    addr1  = 23'h0abcde;
    cnt1   = 24'h000010;
    req_en = 2'b11;
    step(1);
    check("tie_first_addr", 64'(rd_addr), 64'h001000);
    serve(2'b01, 1'b1);
    step(1);
    check("tie_second_addr", 64'(rd_addr), 64'h0abcde);
    check("tie_second_cnt", 64'(rd_cnt), 64'h000010);
    serve(2'b10, 1'b1);
    serve(2'b01, 1'b0);
    serve(2'b10, 1'b0);
    req_en = 2'b00;

    // Zero-count request from requester 1.
    do_reset();
    addr1  = 23'h007abc;
    cnt1   = 24'h000000;
    req_en = 2'b10;
    step(1);
    check("zero_grant", 64'(grant), 64'h2);
    check("zero_done", 64'(done), 64'h2);
    check("zero_err", 64'(err), 64'h0);
    check("zero_en0", 64'(en), 64'h0);
    step(1);
    check("zero_en1", 64'(en), 64'h0);
    req_en = 2'b00;
    step(1);
    check("zero_done_clr", 64'(done), 64'h0);
    check("zero_en2", 64'(en), 64'h0);
    step(1);
    check("zero_grant_clr", 64'(grant), 64'h0);

    // Timeout on the short-watchdog instance.
    do_reset();
    cnt0   = 24'h000005;
    req_en = 2'b01;
    step(1);
    check("tmo_en", 64'(en_t), 64'h1);
    step(14);
    check("tmo_early", 64'(done_t), 64'h0);
    step(1);
    check("tmo_done", 64'(done_t), 64'h1);
    check("tmo_err", 64'(err_t), 64'h1);
    check("tmo_seen", 64'(tmo_t), 64'h1);
    check("tmo_long_wdog", 64'(done), 64'h0);
    req_en = 2'b00;
    step(2);
    check("tmo_grant_clr", 64'(grant_t), 64'h0);
    check("tmo_sticky", 64'(tmo_t), 64'h1);
    clr_timeout = 1'b1;
    step(1);
    clr_timeout = 1'b0;
    check("tmo_clear", 64'(tmo_t), 64'h0);

    // Reset in the middle of a read.
    do_reset();
    addr0  = 23'h002222;
    cnt0   = 24'h000040;
    req_en = 2'b01;
    step(1);
    check("mid_en", 64'(en), 64'h1);
    step(3);
    reset = 1'b0;
    step(1);
    check("mid_grant", 64'(grant), 64'h0);
    check("mid_en_drop", 64'(en), 64'h0);
    check("mid_busy", 64'(busy), 64'h0);
    check("mid_addr", 64'(rd_addr), 64'h0);
    check("mid_cnt", 64'(rd_cnt), 64'h0);
    reset = 1'b1;
    step(1);
    check("mid_regrant", 64'(grant), 64'h1);
    check("mid_readdr", 64'(rd_addr), 64'h002222);
    check("mid_reen", 64'(en), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
